// File: rtl/reg_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_pkg : default geometry and zero-register encoding       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_file_pkg;
  localparam int RF_WIDTH = 32;
  localparam int RF_SIZE  = 5;
  localparam int RF_DEPTH = 32;
  localparam int RF_NREAD = 2;

  localparam bit ZERO_REG_ON  = 1'b1;
  localparam bit ZERO_REG_OFF = 1'b0;
endpackage
`default_nettype wire

// File: rtl/mux_n1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_n1 : DEPTH:1 word selector over a packed storage image       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux_n1
  import reg_file_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int SIZE  = RF_SIZE,
  parameter int DEPTH = RF_DEPTH
) (
  input  logic [DEPTH*WIDTH-1:0] data_in,
  input  logic [SIZE-1:0]        sel,
  output logic [WIDTH-1:0]       data_out
);

  // Selects beyond DEPTH fall through to zero.
  always_comb begin
    data_out = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (sel == SIZE'(d)) data_out = data_in[d*WIDTH +: WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_mport : 1W / NREAD-R register file, registered reads    |
// | with write-first bypass and optional hard-wired zero word.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_file_mport
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int SIZE     = RF_SIZE,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = RF_NREAD,
  parameter bit ZERO_REG = ZERO_REG_ON
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [SIZE-1:0]        wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NREAD-1:0]       rd_en,
  input  logic [NREAD*SIZE-1:0]  rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_valid
);

  localparam logic [SIZE:0] DEPTH_LIM = (SIZE+1)'(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic                   wr_hit;

  // wr_hit is true only when the array really changes; it also qualifies bypass.
  always_comb begin
    wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_LIM) && !(ZERO_REG && (wr_addr == '0));
  end

  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < DEPTH; w++) begin
      if (wr_hit && (wr_addr == SIZE'(w))) mem_d[w] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_flat
    assign mem_flat[w*WIDTH +: WIDTH] = mem_q[w];
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [SIZE-1:0]  addr;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             in_range, bypass;

    assign addr = rd_addr[i*SIZE +: SIZE];

    mux_n1 #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
    ) u_mux (
      .data_in  (mem_flat),
      .sel      (addr),
      .data_out (mux_out)
    );

    always_comb begin
      in_range = ({1'b0, addr} < DEPTH_LIM) && !(ZERO_REG && (addr == '0));
      bypass   = wr_hit && (wr_addr == addr);
      valid_d  = rd_en[i];
      data_d   = data_q;
      if (rd_en[i]) begin
        if (!in_range)   data_d = '0;
        else if (bypass) data_d = wr_data;
        else             data_d = mux_out;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = data_q;
    assign rd_valid[i]               = valid_q;
  end

endmodule
`default_nettype wire
